// File: rtl/t_ff_counter_if.sv
// rtl/t_ff_counter_if.sv - control/status bundle between a counter user and t_ff_counter
interface t_ff_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             ovf;
    logic             div_out;

    modport master (
        output clr, load, load_val, en, up,
        input  q, q_bar, tc, ovf, div_out
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output q, q_bar, tc, ovf, div_out
    );
endinterface

// File: rtl/t_ff_counter.sv
// rtl/t_ff_counter.sv - up/down toggle counter with programmable terminal value, wrap/saturate, tc, ovf and divided output
module t_ff_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    t_ff_counter_if.slave   bus
);
    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             ovf_r;
    logic             div_r;

    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;
    logic             term;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q_r[i-1];
            t_dn[i] = t_dn[i-1] & ~q_r[i-1];
        end
    end

    always_comb begin
        term         = bus.en & (bus.up ? (q_r == MAX_VAL) : (q_r == '0));
        load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        if (term)
            step_val = SATURATE ? q_r : (bus.up ? '0 : MAX_VAL);
        else
            step_val = q_r ^ (bus.up ? t_up : t_dn);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r   <= '0;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
            div_r <= 1'b0;
        end else if (bus.clr) begin
            q_r   <= '0;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (bus.load) begin
            q_r  <= load_clamped;
            tc_r <= 1'b0;
        end else if (bus.en) begin
            q_r  <= step_val;
            tc_r <= term;
            if (term) begin
                ovf_r <= 1'b1;
                div_r <= ~div_r;
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign bus.q       = q_r;
    assign bus.q_bar   = ~q_r;
    assign bus.tc      = tc_r;
    assign bus.ovf     = ovf_r;
    assign bus.div_out = div_r;
endmodule

// File: tb/tb_t_ff_counter.sv
// tb/tb_t_ff_counter.sv - directed self-checking bench for t_ff_counter (wrap and saturate instances)
module tb_t_ff_counter;
    logic clk;
    logic reset_n;
    logic reset_s_n;
    int   vectors;
    int   miscompares;

    t_ff_counter_if #(.WIDTH(4)) bus ();
    t_ff_counter_if #(.WIDTH(4)) bus_s ();

    assign bus_s.clr      = bus.clr;
    assign bus_s.load     = bus.load;
    assign bus_s.load_val = bus.load_val;
    assign bus_s.en       = bus.en;
    assign bus_s.up       = bus.up;

    t_ff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    t_ff_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dut_s (
        .clk     (clk),
        .reset_n (reset_s_n),
        .bus     (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        reset_s_n    = 1'b0;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        step();
        step();
        chk("rst_q", 8'(bus.q), 8'h0);
        chk("rst_qbar", 8'(bus.q_bar), 8'hF);
        chk("rst_tc", 8'(bus.tc), 8'h0);
        chk("rst_ovf", 8'(bus.ovf), 8'h0);
        chk("rst_div", 8'(bus.div_out), 8'h0);
        reset_n = 1'b1;

        // 1: count to 5, then asynchronous reset between edges
        bus.en = 1'b1;
        bus.up = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("t1_q5", 8'(bus.q), 8'h5);
        reset_n = 1'b0;
        #2;
        chk("t1_async_q", 8'(bus.q), 8'h0);
        chk("t1_async_qbar", 8'(bus.q_bar), 8'hF);
        chk("t1_async_tc", 8'(bus.tc), 8'h0);
        chk("t1_async_ovf", 8'(bus.ovf), 8'h0);
        chk("t1_async_div", 8'(bus.div_out), 8'h0);
        step();
        chk("t1_held_q", 8'(bus.q), 8'h0);
        reset_n = 1'b1;

        // 2: count up 11 edges, wrap at 9
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("t2_q_%0d", k), 8'(bus.q), 8'(k % 10));
            chk($sformatf("t2_tc_%0d", k), 8'(bus.tc), (k == 10) ? 8'h1 : 8'h0);
        end
        chk("t2_ovf", 8'(bus.ovf), 8'h1);
        chk("t2_div", 8'(bus.div_out), 8'h1);

        // 3: clear, then count down through two wraps
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("t3_clr_q", 8'(bus.q), 8'h0);
        chk("t3_clr_ovf", 8'(bus.ovf), 8'h0);
        chk("t3_clr_div", 8'(bus.div_out), 8'h1);
        bus.up = 1'b0;
        step();
        chk("t3_wrap_q", 8'(bus.q), 8'h9);
        chk("t3_wrap_tc", 8'(bus.tc), 8'h1);
        chk("t3_wrap_div", 8'(bus.div_out), 8'h0);
        chk("t3_wrap_ovf", 8'(bus.ovf), 8'h1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("t3_dn_q_%0d", k), 8'(bus.q), 8'(9 - k));
            chk($sformatf("t3_dn_tc_%0d", k), 8'(bus.tc), 8'h0);
        end
        step();
        chk("t3_wrap2_q", 8'(bus.q), 8'h9);
        chk("t3_wrap2_tc", 8'(bus.tc), 8'h1);
        chk("t3_wrap2_div", 8'(bus.div_out), 8'h1);

        // 4: saturating instance held at the limit
        reset_s_n    = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        step();
        bus.load = 1'b0;
        chk("t4_load_q", 8'(bus_s.q), 8'h9);
        chk("t4_load_div", 8'(bus_s.div_out), 8'h0);
        bus.en = 1'b1;
        bus.up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("t4_q_%0d", k), 8'(bus_s.q), 8'h9);
            chk($sformatf("t4_tc_%0d", k), 8'(bus_s.tc), 8'h1);
            chk($sformatf("t4_div_%0d", k), 8'(bus_s.div_out), 8'(k % 2));
        end
        chk("t4_ovf", 8'(bus_s.ovf), 8'h1);
        chk("t4_qbar", 8'(bus_s.q_bar), 8'h6);

        // 5: clamped load, load beats en, clr beats load
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'd12;
        step();
        chk("t5_clamp_q", 8'(bus.q), 8'h9);
        chk("t5_clamp_tc", 8'(bus.tc), 8'h0);
        chk("t5_clamp_ovf", 8'(bus.ovf), 8'h1);
        bus.en       = 1'b1;
        bus.load_val = 4'd3;
        step();
        chk("t5_load_en_q", 8'(bus.q), 8'h3);
        step();
        chk("t5_load_en_q2", 8'(bus.q), 8'h3);
        bus.clr = 1'b1;
        step();
        bus.clr  = 1'b0;
        bus.load = 1'b0;
        bus.en   = 1'b0;
        chk("t5_clr_q", 8'(bus.q), 8'h0);
        chk("t5_clr_ovf", 8'(bus.ovf), 8'h0);

        // 6: hold with en=0, then direction flip every edge
        bus.load     = 1'b1;
        bus.load_val = 4'd7;
        step();
        bus.load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("t6_hold_q_%0d", k), 8'(bus.q), 8'h7);
            chk($sformatf("t6_hold_tc_%0d", k), 8'(bus.tc), 8'h0);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.up = (k % 2 == 1);
            step();
            chk($sformatf("t6_flip_q_%0d", k), 8'(bus.q), (k % 2 == 1) ? 8'h8 : 8'h7);
            chk($sformatf("t6_flip_tc_%0d", k), 8'(bus.tc), 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
